// File: rtl/mux_sync_tx_sched.sv
// mux_sync_tx_sched: round-robin scheduler sharing one mux_sync source port among NREQ requesters.
// Each winning word is held valid for HOLD_CYC cycles, then an idle window of GAP_CYC cycles follows.
module mux_sync_tx_sched #(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 4
) (
  input  logic                     i_clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*DWIDTH-1:0]   i_req_data,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [DWIDTH-1:0]        o_src_data,
  output logic                     o_src_valid,
  output logic [$clog2(NREQ)-1:0]  o_grant_id,
  output logic                     o_busy
);
  localparam int PW   = $clog2(NREQ);
  localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_nxt;
  logic            w_any;
  // Search from the pointer upward with wrap; the first requester found wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && i_req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
      w_idx = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end
  assign w_nxt       = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign o_req_ready = (rst_n && r_state == IDLE && w_any) ? (NREQ'(1) << w_win) : '0;
  assign o_busy      = (r_state != IDLE);
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      o_src_data  <= '0;
      o_src_valid <= 1'b0;
      o_grant_id  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          o_src_data  <= i_req_data[w_win*DWIDTH +: DWIDTH];
          o_src_valid <= 1'b1;
          o_grant_id  <= w_win;
          r_ptr       <= w_nxt;
          r_cnt       <= HOLD_LD;
          r_state     <= HOLD;
        end
        HOLD: if (r_cnt == '0) begin
          o_src_valid <= 1'b0;
          r_cnt       <= GAP_LD;
          r_state     <= (GAP_CYC > 0) ? GAP : IDLE;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        GAP: if (r_cnt == '0) begin
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_sync_tx_sched.sv
// tb_mux_sync_tx_sched: randomized check of the scheduler against a timeline model of accepts.
// The model tracks only the last accept cycle, the rotation pointer and the last accepted word.
module tb_mux_sync_tx_sched;
  localparam int NREQ = 4, DW = 4, HOLD = 16, GAP = 4, PW = $clog2(NREQ);
  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_v;
  logic [NREQ*DW-1:0]   req_d;
  logic [NREQ-1:0]      o_req_ready;
  logic [DW-1:0]        o_src_data;
  logic                 o_src_valid;
  logic [PW-1:0]        o_grant_id;
  logic                 o_busy;
  int n_vec = 0, n_err = 0;
  int cyc = 0, last_acc = 0, ptr = 0, m_gid = 0;
  bit acc_any = 0;
  logic [DW-1:0]   m_data = '0;
  logic [NREQ-1:0] acc_mask = '0;

  mux_sync_tx_sched #(.NREQ(NREQ), .DWIDTH(DW), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
    .i_clk(clk), .rst_n(rst_n), .i_req_valid(req_v), .i_req_data(req_d),
    .o_req_ready(o_req_ready), .o_src_data(o_src_data), .o_src_valid(o_src_valid),
    .o_grant_id(o_grant_id), .o_busy(o_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    acc_any = 0; ptr = 0; m_gid = 0; m_data = '0; acc_mask = '0;
  endtask

  // Called at a negedge; drives inputs, checks outputs, advances the model, returns at the next negedge.
  task automatic do_cycle(input bit rnd);
    int hs, win;
    bit busy_m, val_m, found;
    logic [NREQ-1:0] exp_rdy;
    if (rnd) begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_v[k] && acc_mask[k]) req_v[k] = 1'b0;
        else if (req_v[k]) begin
          if ($urandom_range(39) == 0) req_v[k] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          req_v[k] = 1'b1;
          req_d[k*DW +: DW] = DW'($urandom);
        end
      end
    end
    #1;
    hs = cyc - last_acc;
    busy_m = acc_any && hs >= 1 && hs <= HOLD + GAP;
    val_m  = acc_any && hs >= 1 && hs <= HOLD;
    exp_rdy = '0; found = 0; win = 0;
    if (!busy_m)
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (ptr + k) % NREQ;
        if (!found && req_v[j]) begin found = 1; win = j; exp_rdy[j] = 1'b1; end
      end
    chk("ready", 32'(o_req_ready), 32'(exp_rdy));
    chk("valid", 32'(o_src_valid), 32'(val_m));
    chk("busy",  32'(o_busy), 32'(busy_m));
    chk("data",  32'(o_src_data), 32'(m_data));
    chk("gid",   32'(o_grant_id), 32'(m_gid));
    acc_mask = exp_rdy;
    if (found) begin
      acc_any = 1; last_acc = cyc; m_gid = win;
      m_data = req_d[win*DW +: DW];
      ptr = (win + 1) % NREQ;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_v = '0; req_d = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(o_src_valid), 0);
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_data",  32'(o_src_data), 0);
    chk("rst_gid",   32'(o_grant_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NREQ; k++) req_d[k*DW +: DW] = DW'(k + 1);
    req_v = '1;
    repeat (110) do_cycle(0);
    repeat (1500) do_cycle(1);
    begin
      bit hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
        if (acc_any && cyc - last_acc == 8) hit = 1;
        else do_cycle(1);
      end
      chk("reach_hold8", 32'(hit), 1);
    end
    rst_n = 1'b0;
    req_v = 4'b0100;
    req_d = 16'h0A00;
    #1;
    chk("mid_rst_valid", 32'(o_src_valid), 0);
    chk("mid_rst_data",  32'(o_src_data), 0);
    chk("mid_rst_busy",  32'(o_busy), 0);
    chk("mid_rst_ready", 32'(o_req_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(o_req_ready), 32'h4);
    do_cycle(0);
    repeat (600) do_cycle(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
